triage_engine: RTL and testbench

- Parametrised stroke-triage state machine: N_SENS sensor bits in, N_ACT actuator bits out.
- Adds three behaviours: persistence filtering on every sensor-driven transition, a PRE_CRITICAL dwell timeout that escalates to CRITICAL, and an acknowledge path out of CRITICAL.
- Also provides a saturating count of CRITICAL entries and an escalation pulse.
- Sits between sensor conditioning and actuator drivers.

---
 rtl/triage_engine.sv | 151 +++++++++++++++
 tb/tb_triage_engine.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triage_engine.sv
// Stroke-triage FSM: IDLE/OBSERVATION/PRE_CRITICAL/CRITICAL with persistence filter, dwell timeout, ACK exit.
// Latency: sensor-driven moves after PERSIST consecutive qualifying edges; ACK exit and timeout take one edge.
// Backpressure: none; S and ACK are sampled every cycle, and outputs A/STATE/ESC/CRIT_CNT are all registered.
// Ports: CLK/RST (async, active-high) | S sensor vector, ACK acknowledge |
//        A actuator pattern, STATE present state, ESC timeout pulse, CRIT_CNT saturating CRITICAL entry count.
module triage_engine #(
    parameter int                N_SENS      = 6,
    parameter int                N_ACT       = 6,
    parameter logic [N_SENS-1:0] HIGH_MASK   = 6'b001111,
    parameter logic [N_SENS-1:0] LOW_MASK    = 6'b110000,
    parameter int                H_THRESH    = 2,
    parameter int                PERSIST     = 3,
    parameter int                PRE_TIMEOUT = 16,
    parameter int                CNT_W       = 8,
    parameter logic [N_ACT-1:0]  ACT_IDLE    = 6'b000000,
    parameter logic [N_ACT-1:0]  ACT_OBS     = 6'b001100,
    parameter logic [N_ACT-1:0]  ACT_PRE     = 6'b011010,
    parameter logic [N_ACT-1:0]  ACT_CRIT    = 6'b111111
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_SENS-1:0] S,
    input  logic              ACK,
    output logic [N_ACT-1:0]  A,
    output logic [1:0]        STATE,
    output logic              ESC,
    output logic [CNT_W-1:0]  CRIT_CNT
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OBS  = 2'b01,
        ST_PRE  = 2'b10,
        ST_CRIT = 2'b11
    } state_t;

    localparam int HCW = $clog2(N_SENS + 1);
    localparam int PW  = $clog2(PERSIST + 1);
    localparam int DW  = (PRE_TIMEOUT > 1) ? $clog2(PRE_TIMEOUT) : 1;

    state_t             r_state;
    state_t             r_cand;
    logic [PW-1:0]      r_pcnt;
    logic [DW-1:0]      r_dwell;
    logic               r_esc;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_ACT-1:0]   r_act;

    logic [N_SENS-1:0]  w_shi;
    logic [HCW-1:0]     w_hcnt;
    logic               w_n;
    logic               w_h;
    logic               w_l1;
    logic               w_timeout;
    state_t             w_tgt;
    state_t             w_nxt;
    state_t             w_cand_nxt;
    logic [PW-1:0]      w_pcnt_nxt;
    logic               w_esc;

    function automatic logic [N_ACT-1:0] act_of(input state_t st);
        case (st)
            ST_IDLE: act_of = ACT_IDLE;
            ST_OBS:  act_of = ACT_OBS;
            ST_PRE:  act_of = ACT_PRE;
            ST_CRIT: act_of = ACT_CRIT;
            default: act_of = ACT_IDLE;
        endcase
    endfunction

    assign w_shi = S & HIGH_MASK;

    always_comb begin
        w_hcnt = '0;
        for (int i = 0; i < N_SENS; i++) begin
            w_hcnt = w_hcnt + HCW'(w_shi[i]);
        end
    end

    assign w_n  = (S == '0);
    assign w_h  = (w_hcnt >= HCW'(H_THRESH));
    assign w_l1 = (|(S & LOW_MASK)) & ~w_h;

    // Requested target for this cycle, before any persistence filtering.
    always_comb begin
        w_tgt = ST_IDLE;
        case (r_state)
            ST_IDLE: w_tgt = w_h ? ST_PRE : (w_l1 ? ST_OBS : ST_IDLE);
            ST_OBS:  w_tgt = w_h ? ST_PRE : (w_n ? ST_IDLE : ST_OBS);
            ST_PRE:  w_tgt = (w_h | w_l1) ? ST_CRIT : (w_n ? ST_IDLE : ST_PRE);
            ST_CRIT: w_tgt = (ACK & w_n) ? ST_OBS : ST_CRIT;
            default: w_tgt = ST_IDLE;
        endcase
    end

    assign w_timeout = (r_state == ST_PRE) && (r_dwell == DW'(PRE_TIMEOUT - 1));

    // Count of consecutive identical differing requests includes this cycle;
    // a stored count of zero means no run is in progress.
    always_comb begin
        w_cand_nxt = r_cand;
        w_pcnt_nxt = '0;
        w_esc      = 1'b0;
        w_nxt      = r_state;
        if (w_tgt != r_state) begin
            w_cand_nxt = w_tgt;
            w_pcnt_nxt = ((w_tgt == r_cand) && (r_pcnt != '0)) ? r_pcnt + PW'(1) : PW'(1);
        end
        if (w_timeout) begin
            // Timeout overrides any qualified exit landing on the same edge.
            w_nxt = ST_CRIT;
            w_esc = 1'b1;
        end else if (r_state == ST_CRIT) begin
            if (ACK && w_n) w_nxt = ST_OBS;
        end else if ((w_tgt != r_state) && (w_pcnt_nxt >= PW'(PERSIST))) begin
            w_nxt = w_tgt;
        end
        if (w_nxt != r_state) w_pcnt_nxt = '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cand  <= ST_IDLE;
            r_pcnt  <= '0;
            r_dwell <= '0;
            r_esc   <= 1'b0;
            r_cnt   <= '0;
            r_act   <= ACT_IDLE;
        end else begin
            r_state <= w_nxt;
            r_cand  <= w_cand_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_esc   <= w_esc;
            r_act   <= act_of(w_nxt);
            if (w_nxt != r_state) begin
                r_dwell <= '0;
            end else if (r_state == ST_PRE) begin
                r_dwell <= r_dwell + DW'(1);
            end
            if ((w_nxt == ST_CRIT) && (r_state != ST_CRIT) && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign A        = r_act;
    assign STATE    = r_state;
    assign ESC      = r_esc;
    assign CRIT_CNT = r_cnt;

endmodule

// File: tb/tb_triage_engine.sv
// Bench for triage_engine: default build plus a PERSIST=1 / CNT_W=2 build.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: not applicable; inputs are driven freely every cycle.
module tb_triage_engine;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] S = '0, S2 = '0;
    logic       ACK = 1'b0, ACK2 = 1'b0;
    logic [5:0] A, A2;
    logic [1:0] STATE, STATE2;
    logic       ESC, ESC2;
    logic [7:0] CRIT_CNT;
    logic [1:0] CRIT_CNT2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    triage_engine u_dut (
        .CLK(CLK), .RST(RST), .S(S), .ACK(ACK),
        .A(A), .STATE(STATE), .ESC(ESC), .CRIT_CNT(CRIT_CNT)
    );

    triage_engine #(.PERSIST(1), .CNT_W(2)) u_sat (
        .CLK(CLK), .RST(RST), .S(S2), .ACK(ACK2),
        .A(A2), .STATE(STATE2), .ESC(ESC2), .CRIT_CNT(CRIT_CNT2)
    );

    // Reference model, per instance: state numbers 0..3, the list of recent
    // requested targets since the last state change, edges spent in PRE.
    int m_state[2], m_dwell[2], m_cnt[2], m_esc[2], m_hlen[2];
    int m_hist[2][8];
    int m_pers[2] = '{3, 1};
    int m_cmax[2] = '{255, 3};

    function automatic logic [5:0] act_of(input int st);
        case (st)
            0:       act_of = 6'b000000;
            1:       act_of = 6'b001100;
            2:       act_of = 6'b011010;
            default: act_of = 6'b111111;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0; m_dwell[k] = 0; m_cnt[k] = 0; m_esc[k] = 0; m_hlen[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic [5:0] s, input logic ack);
        int  st, tgt, nxt;
        bit  n, h, l1, same;
        st  = m_state[k];
        n   = (s == 6'd0);
        h   = ($countones(s & 6'b001111) >= 2);
        l1  = ((s & 6'b110000) != 6'd0) && !h;
        case (st)
            0:       tgt = h ? 2 : (l1 ? 1 : 0);
            1:       tgt = h ? 2 : (n ? 0 : 1);
            2:       tgt = (h || l1) ? 3 : (n ? 0 : 2);
            default: tgt = (ack && n) ? 1 : 3;
        endcase
        nxt = st;
        m_esc[k] = 0;
        if (st == 2 && m_dwell[k] + 1 == 16) begin
            nxt = 3;
            m_esc[k] = 1;
        end else if (st == 3) begin
            if (ack && n) nxt = 1;
        end else begin
            for (int i = 7; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
            m_hist[k][0] = tgt;
            if (m_hlen[k] < 8) m_hlen[k]++;
            same = (m_hlen[k] >= m_pers[k]);
            for (int i = 0; i < m_pers[k]; i++) if (m_hist[k][i] != tgt) same = 0;
            if (same && tgt != st) nxt = tgt;
        end
        if (nxt != st) begin
            m_hlen[k]  = 0;
            m_dwell[k] = 0;
            if (nxt == 3 && m_cnt[k] < m_cmax[k]) m_cnt[k]++;
        end else if (st == 2) begin
            m_dwell[k]++;
        end
        m_state[k] = nxt;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step(0, S, ACK);
        model_step(1, S2, ACK2);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; S = '0; ACK = 1'b0; S2 = '0; ACK2 = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        model_reset();
        n_tests++;
        if ({STATE, A, ESC, CRIT_CNT} !== {2'b00, 6'b000000, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_main got st=%b a=%b esc=%b cnt=%0d exp 00/000000/0/0", STATE, A, ESC, CRIT_CNT);
        end
        n_tests++;
        if ({STATE2, A2, ESC2, CRIT_CNT2} !== {2'b00, 6'b000000, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_sat got st=%b a=%b esc=%b cnt=%0d exp 00/000000/0/0", STATE2, A2, ESC2, CRIT_CNT2);
        end
        RST = 1'b0;
    endtask

    task automatic test_persistence();
        S = 6'b010000; tick(); tick();
        S = 6'b000000; tick();
        n_tests++;
        if (STATE !== 2'b00) begin
            n_fail++; $display("FAIL persist_short got st=%b exp 00", STATE);
        end
        S = 6'b010000; tick(); tick();
        n_tests++;
        if (STATE !== 2'b00) begin
            n_fail++; $display("FAIL persist_2nd_edge got st=%b exp 00", STATE);
        end
        tick();
        n_tests++;
        if ({STATE, A} !== {2'b01, 6'b001100}) begin
            n_fail++; $display("FAIL persist_3rd_edge got st=%b a=%b exp 01/001100", STATE, A);
        end
        S = 6'b000000; repeat (3) tick();
        n_tests++;
        if (STATE !== 2'b00) begin
            n_fail++; $display("FAIL obs_to_idle got st=%b exp 00", STATE);
        end
        for (int i = 0; i < 8; i++) begin
            S = i[0] ? 6'b000011 : 6'b010000;
            tick();
            n_tests++;
            if (STATE !== 2'b00) begin
                n_fail++; $display("FAIL persist_alternate cyc=%0d got st=%b exp 00", i, STATE);
            end
        end
    endtask

    task automatic test_escalation();
        S = 6'b000011; repeat (3) tick();
        n_tests++;
        if ({STATE, A} !== {2'b10, 6'b011010}) begin
            n_fail++; $display("FAIL esc_to_pre got st=%b a=%b exp 10/011010", STATE, A);
        end
        S = 6'b100000; repeat (3) tick();
        n_tests++;
        if ({STATE, A, CRIT_CNT, ESC} !== {2'b11, 6'b111111, 8'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL esc_to_crit got st=%b a=%b cnt=%0d esc=%b exp 11/111111/1/0", STATE, A, CRIT_CNT, ESC);
        end
    endtask

    task automatic test_ack();
        ACK = 1'b1; S = 6'b000011;
        repeat (5) tick();
        n_tests++;
        if (STATE !== 2'b11) begin
            n_fail++; $display("FAIL ack_not_quiet got st=%b exp 11", STATE);
        end
        S = 6'b000000; tick();
        n_tests++;
        if ({STATE, A} !== {2'b01, 6'b001100}) begin
            n_fail++; $display("FAIL ack_exit got st=%b a=%b exp 01/001100", STATE, A);
        end
        ACK = 1'b0; repeat (3) tick();
        ACK = 1'b1; repeat (4) tick();
        n_tests++;
        if (STATE !== 2'b00) begin
            n_fail++; $display("FAIL ack_in_idle got st=%b exp 00", STATE);
        end
        ACK = 1'b0;
    endtask

    // mode 0: hold neutral S; 1: IDLE exit coincides; 2: CRITICAL exit coincides
    task automatic test_timeout(input int mode);
        int cnt0;
        S = 6'b000011; repeat (3) tick();
        cnt0 = int'(CRIT_CNT);
        for (int e = 1; e <= 16; e++) begin
            if (e >= 14 && mode == 1)      S = 6'b000000;
            else if (e >= 14 && mode == 2) S = 6'b100000;
            else                           S = 6'b000001;
            tick();
            n_tests++;
            if (e < 16 && {STATE, ESC} !== {2'b10, 1'b0}) begin
                n_fail++; $display("FAIL timeout_dwell m=%0d edge=%0d got st=%b esc=%b exp 10/0", mode, e, STATE, ESC);
            end else if (e == 16 && {STATE, ESC, CRIT_CNT} !== {2'b11, 1'b1, 8'(cnt0 + 1)}) begin
                n_fail++;
                $display("FAIL timeout_fire m=%0d got st=%b esc=%b cnt=%0d exp 11/1/%0d", mode, STATE, ESC, CRIT_CNT, cnt0 + 1);
            end
        end
        tick();
        n_tests++;
        if ({STATE, ESC} !== {2'b11, 1'b0}) begin
            n_fail++; $display("FAIL timeout_pulse_width m=%0d got st=%b esc=%b exp 11/0", mode, STATE, ESC);
        end
        if (mode != 2) begin
            ACK = 1'b1; S = 6'b000000; tick();
            ACK = 1'b0; repeat (3) tick();
        end
    endtask

    task automatic test_async_reset();
        n_tests++;
        if (STATE !== 2'b11) begin
            n_fail++; $display("FAIL async_precond got st=%b exp 11", STATE);
        end
        @(posedge CLK);
        model_step(0, S, ACK);
        model_step(1, S2, ACK2);
        #2 RST = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if ({STATE, A, CRIT_CNT} !== {2'b00, 6'b000000, 8'd0}) begin
            n_fail++; $display("FAIL async_reset got st=%b a=%b cnt=%0d exp 00/000000/0", STATE, A, CRIT_CNT);
        end
        @(posedge CLK);
        #1 RST = 1'b0;
        S = '0;
    endtask

    task automatic test_saturation();
        int exp_cnt[5] = '{1, 2, 3, 3, 3};
        for (int i = 0; i < 5; i++) begin
            S2 = 6'b000011; tick();
            n_tests++;
            if (STATE2 !== 2'b10) begin
                n_fail++; $display("FAIL p1_to_pre iter=%0d got st=%b exp 10", i, STATE2);
            end
            S2 = 6'b100000; tick();
            n_tests++;
            if ({STATE2, CRIT_CNT2} !== {2'b11, 2'(exp_cnt[i])}) begin
                n_fail++; $display("FAIL sat_cnt iter=%0d got st=%b cnt=%0d exp 11/%0d", i, STATE2, CRIT_CNT2, exp_cnt[i]);
            end
            ACK2 = 1'b1; S2 = 6'b000000; tick();
            ACK2 = 1'b0;
            n_tests++;
            if (STATE2 !== 2'b01) begin
                n_fail++; $display("FAIL p1_ack_exit iter=%0d got st=%b exp 01", i, STATE2);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] pat[6] = '{6'b000000, 6'b000001, 6'b000011, 6'b010000, 6'b100000, 6'b001000};
        int hold0 = 0, hold1 = 0, idx;
        for (int c = 0; c < 3000; c++) begin
            if (hold0 == 0) begin
                idx = $urandom_range(0, 6);
                S = (idx == 6) ? 6'($urandom) : pat[idx];
                hold0 = $urandom_range(1, 20);
            end
            if (hold1 == 0) begin
                idx = $urandom_range(0, 6);
                S2 = (idx == 6) ? 6'($urandom) : pat[idx];
                hold1 = $urandom_range(1, 6);
            end
            hold0--; hold1--;
            ACK  = ($urandom_range(0, 3) == 0);
            ACK2 = ($urandom_range(0, 3) == 0);
            tick();
            n_tests++;
            if ({STATE, A, ESC, CRIT_CNT} !== {2'(m_state[0]), act_of(m_state[0]), 1'(m_esc[0]), 8'(m_cnt[0])}) begin
                n_fail++;
                $display("FAIL rand_main cyc=%0d got st=%0d a=%b esc=%b cnt=%0d exp st=%0d a=%b esc=%0d cnt=%0d",
                         c, STATE, A, ESC, CRIT_CNT, m_state[0], act_of(m_state[0]), m_esc[0], m_cnt[0]);
            end
            n_tests++;
            if ({STATE2, A2, ESC2, CRIT_CNT2} !== {2'(m_state[1]), act_of(m_state[1]), 1'(m_esc[1]), 2'(m_cnt[1])}) begin
                n_fail++;
                $display("FAIL rand_sat cyc=%0d got st=%0d a=%b esc=%b cnt=%0d exp st=%0d a=%b esc=%0d cnt=%0d",
                         c, STATE2, A2, ESC2, CRIT_CNT2, m_state[1], act_of(m_state[1]), m_esc[1], m_cnt[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_persistence();
        test_escalation();
        test_ack();
        test_timeout(0);
        test_timeout(1);
        test_timeout(2);
        test_async_reset();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
